// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, DATA_WIDTH serializer bits, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to add the stop2 input (two stop bits per frame when set on accept).
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic                  ser_data,
`ifdef UART_TX_TWO_STOP_EN
  input  logic                  stop2,
`endif
  output logic                  ser_en,
  output logic [CNT_W-1:0]      bit_idx,
  output logic                  tx_out,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_par_bit;
  logic             r_par_en;
  logic             w_accept;
  logic             w_final_stop;

`ifdef UART_TX_TWO_STOP_EN
  logic r_stop2;

  // With two stop bits the counter marks the second stop cycle as the final one.
  assign w_final_stop = !r_stop2 || (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stop2 <= 1'b0;
    end else if (w_accept) begin
      r_stop2 <= stop2;
    end
  end
`else
  assign w_final_stop = 1'b1;
`endif

  assign w_accept = data_valid && !busy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_par_en  <= par_en;
        r_par_bit <= (^p_data) ^ par_type;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (w_accept) begin
          w_state_next = START;
        end
      end
      START: begin
        w_state_next = DATA;
        w_cnt_next   = '0;
      end
      DATA: begin
        if (r_cnt == LAST_BIT) begin
          w_state_next = r_par_en ? PARITY : STOP;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        w_state_next = STOP;
        w_cnt_next   = '0;
      end
      STOP: begin
        if (w_final_stop) begin
          w_state_next = w_accept ? START : IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    ser_en  = 1'b0;
    bit_idx = '0;
    tx_out  = 1'b1;
    busy    = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
      end
      START: begin
        tx_out = 1'b0;
      end
      DATA: begin
        ser_en  = 1'b1;
        bit_idx = r_cnt;
        tx_out  = ser_data;
      end
      PARITY: begin
        tx_out = r_par_bit;
      end
      STOP: begin
        busy = !w_final_stop;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl; serializer modelled as tb_byte[bit_idx].
// Build with UART_TX_TWO_STOP_EN defined to also exercise the two-stop-bit frame.
module tb_uart_tx_ctrl;

  logic       clk;
  logic       rstn;
  logic       data_valid;
  logic [7:0] p_data;
  logic       par_en;
  logic       par_type;
  logic       ser_data;
  logic       stop2;
  logic       ser_en;
  logic [3:0] bit_idx;
  logic       tx_out;
  logic       busy;

  logic [7:0] tb_byte;
  int         chk_cnt;
  int         pass_cnt;

  uart_tx_ctrl #(.DATA_WIDTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .data_valid (data_valid),
    .p_data     (p_data),
    .par_en     (par_en),
    .par_type   (par_type),
    .ser_data   (ser_data),
`ifdef UART_TX_TWO_STOP_EN
    .stop2      (stop2),
`endif
    .ser_en     (ser_en),
    .bit_idx    (bit_idx),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  assign ser_data = tb_byte[bit_idx[2:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Sends one frame and records the line, busy, ser_en and bit_idx on the falling edge of each cycle.
  // Frame configuration is inverted right after accept to show it was latched.
  task automatic capture(input logic [7:0] b, input logic pe, input logic pt, input logic s2,
                         input int len, output logic [15:0] line, output logic [15:0] bz,
                         output logic [15:0] se, output logic [63:0] idx);
    line = '1;
    bz   = '0;
    se   = '0;
    idx  = '0;
    @(negedge clk);
    p_data = b; tb_byte = b; par_en = pe; par_type = pt; stop2 = s2; data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0; par_en = ~pe; par_type = ~pt; stop2 = ~s2;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      line[i]      = tx_out;
      bz[i]        = busy;
      se[i]        = ser_en;
      idx[i*4 +: 4] = bit_idx;
    end
    par_en = 1'b0; par_type = 1'b0; stop2 = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; data_valid = 1'b0; p_data = 8'h00; par_en = 1'b0; par_type = 1'b0;
    stop2 = 1'b0; tb_byte = 8'h00;
    #12;
    chk_cnt++;
    if ({tx_out, busy, ser_en, bit_idx} !== {1'b1, 1'b0, 1'b0, 4'd0})
      $display("FAIL reset_outputs: got %b want %b", {tx_out, busy, ser_en, bit_idx}, 7'b1000000);
    else pass_cnt++;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_cnt++;
      if ({tx_out, busy, ser_en} !== 3'b100)
        $display("FAIL idle_cycle%0d: got tx/busy/ser_en=%b want 100", i, {tx_out, busy, ser_en});
      else pass_cnt++;
    end
  endtask

  task automatic test_frame_a5();
    logic [15:0] line, bz, se;
    logic [63:0] idx, exp_idx;
    capture(8'hA5, 1'b0, 1'b0, 1'b0, 10, line, bz, se, idx);
    exp_idx = '0;
    for (int i = 1; i <= 8; i++) exp_idx[i*4 +: 4] = 4'(i - 1);
    chk_cnt++;
    if (line !== {6'h3F, 1'b1, 8'hA5, 1'b0})
      $display("FAIL a5_line: got %h want %h", line, {6'h3F, 1'b1, 8'hA5, 1'b0});
    else pass_cnt++;
    chk_cnt++;
    if (bz !== 16'h01FF) $display("FAIL a5_busy: got %h want 01ff", bz);
    else pass_cnt++;
    chk_cnt++;
    if (se !== 16'h01FE) $display("FAIL a5_ser_en: got %h want 01fe", se);
    else pass_cnt++;
    chk_cnt++;
    if (idx !== exp_idx) $display("FAIL a5_bit_idx: got %h want %h", idx, exp_idx);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({tx_out, busy} !== 2'b10) $display("FAIL a5_return_idle: got %b want 10", {tx_out, busy});
    else pass_cnt++;
  endtask

  task automatic test_parity();
    logic [15:0] line, bz, se;
    logic [63:0] idx;
    capture(8'h07, 1'b1, 1'b0, 1'b0, 11, line, bz, se, idx);
    chk_cnt++;
    if (line !== {5'h1F, 1'b1, 1'b1, 8'h07, 1'b0})
      $display("FAIL even_parity_line: got %h want %h", line, {5'h1F, 1'b1, 1'b1, 8'h07, 1'b0});
    else pass_cnt++;
    chk_cnt++;
    if (bz !== 16'h03FF) $display("FAIL even_parity_busy: got %h want 03ff", bz);
    else pass_cnt++;
    capture(8'h07, 1'b1, 1'b1, 1'b0, 11, line, bz, se, idx);
    chk_cnt++;
    if (line !== {5'h1F, 1'b1, 1'b0, 8'h07, 1'b0})
      $display("FAIL odd_parity_line: got %h want %h", line, {5'h1F, 1'b1, 1'b0, 8'h07, 1'b0});
    else pass_cnt++;
    chk_cnt++;
    if ({bz, se} !== {16'h03FF, 16'h01FE})
      $display("FAIL odd_parity_busy_ser_en: got %h want 03ff01fe", {bz, se});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] line, bz;
    int          se_total;
    line = '1; bz = '0; se_total = 0;
    @(negedge clk);
    p_data = 8'h00; tb_byte = 8'h00; par_en = 1'b0; par_type = 1'b0; data_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      line[c] = tx_out;
      bz[c]   = busy;
      if (ser_en) se_total++;
      if (c == 9)  begin p_data = 8'hFF; tb_byte = 8'hFF; end
      if (c == 19) begin p_data = 8'h3C; tb_byte = 8'h3C; end
      if (c == 29) data_valid = 1'b0;
    end
    chk_cnt++;
    if (line !== {2'b11, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0})
      $display("FAIL b2b_line: got %h want %h", line,
               {2'b11, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0});
    else pass_cnt++;
    chk_cnt++;
    if (bz !== {2'b00, 10'h1FF, 10'h1FF, 10'h1FF})
      $display("FAIL b2b_busy: got %h want %h", bz, {2'b00, 10'h1FF, 10'h1FF, 10'h1FF});
    else pass_cnt++;
    chk_cnt++;
    if (se_total !== 24) $display("FAIL b2b_ser_en_count: got %0d want 24", se_total);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({tx_out, busy} !== 2'b10) $display("FAIL b2b_return_idle: got %b want 10", {tx_out, busy});
    else pass_cnt++;
  endtask

  task automatic test_ignore_busy();
    logic [10:0] line, bz;
    line = '1; bz = '0;
    @(negedge clk);
    p_data = 8'h3C; tb_byte = 8'h3C; par_en = 1'b0; par_type = 1'b0; data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      line[c] = tx_out;
      bz[c]   = busy;
      if (c == 4) begin data_valid = 1'b1; par_en = 1'b1; end
      if (c == 5) begin data_valid = 1'b0; par_en = 1'b0; end
    end
    chk_cnt++;
    if (line !== {1'b1, 1'b1, 8'h3C, 1'b0})
      $display("FAIL ignore_line: got %h want %h", line, {1'b1, 1'b1, 8'h3C, 1'b0});
    else pass_cnt++;
    chk_cnt++;
    if (bz !== 11'h1FF) $display("FAIL ignore_busy: got %h want 1ff", bz);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] line, bz, se;
    logic [63:0] idx;
    @(negedge clk);
    p_data = 8'hEF; tb_byte = 8'hEF; par_en = 1'b0; par_type = 1'b0; data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk_cnt++;
    if ({bit_idx, ser_en, tx_out, busy} !== {4'd4, 1'b1, 1'b0, 1'b1})
      $display("FAIL pre_reset_bit4: got %b want 0100101", {bit_idx, ser_en, tx_out, busy});
    else pass_cnt++;
    rstn = 1'b0;
    #1;
    chk_cnt++;
    if ({tx_out, busy, ser_en, bit_idx} !== {1'b1, 1'b0, 1'b0, 4'd0})
      $display("FAIL async_reset: got %b want 1000000", {tx_out, busy, ser_en, bit_idx});
    else pass_cnt++;
    @(negedge clk);
    rstn = 1'b1;
    capture(8'h5A, 1'b1, 1'b1, 1'b0, 11, line, bz, se, idx);
    chk_cnt++;
    if (line !== {5'h1F, 1'b1, 1'b1, 8'h5A, 1'b0})
      $display("FAIL post_reset_line: got %h want %h", line, {5'h1F, 1'b1, 1'b1, 8'h5A, 1'b0});
    else pass_cnt++;
    chk_cnt++;
    if ({bz, se} !== {16'h03FF, 16'h01FE})
      $display("FAIL post_reset_busy_ser_en: got %h want 03ff01fe", {bz, se});
    else pass_cnt++;
  endtask

`ifdef UART_TX_TWO_STOP_EN
  task automatic test_two_stop();
    logic [15:0] line, bz, se;
    logic [63:0] idx;
    capture(8'h81, 1'b1, 1'b0, 1'b1, 12, line, bz, se, idx);
    chk_cnt++;
    if (line !== {4'hF, 1'b1, 1'b1, 1'b0, 8'h81, 1'b0})
      $display("FAIL two_stop_line: got %h want %h", line, {4'hF, 1'b1, 1'b1, 1'b0, 8'h81, 1'b0});
    else pass_cnt++;
    chk_cnt++;
    if ({bz, se} !== {16'h07FF, 16'h01FE})
      $display("FAIL two_stop_busy_ser_en: got %h want 07ff01fe", {bz, se});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({tx_out, busy} !== 2'b10) $display("FAIL two_stop_return_idle: got %b want 10", {tx_out, busy});
    else pass_cnt++;
  endtask
`endif

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    test_reset();
    test_frame_a5();
    test_parity();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
`ifdef UART_TX_TWO_STOP_EN
    test_two_stop();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
